// File: rtl/kim_fifo_mem_ptr_if.sv
// kim_fifo_mem_ptr_if
// Bundle between the FIFO valid/ready control stage (master) and the
// storage/pointer stage (slave).
//   master -> slave : w_hs, r_hs, w_data, err_clr
//   slave -> master : r_data, w_ptr, r_ptr, w_back_out, r_back_out,
//                     count, almost_full, almost_empty, overflow, underflow
interface kim_fifo_mem_ptr_if #(
    parameter int FIFO_DATA_LENGTH = 32,
    parameter int FIFO_LOG2_DEPTH  = 2
);
    logic                        w_hs;
    logic                        r_hs;
    logic [FIFO_DATA_LENGTH-1:0] w_data;
    logic                        err_clr;
    logic [FIFO_DATA_LENGTH-1:0] r_data;
    logic [FIFO_LOG2_DEPTH-1:0]  w_ptr;
    logic [FIFO_LOG2_DEPTH-1:0]  r_ptr;
    logic                        w_back_out;
    logic                        r_back_out;
    logic [FIFO_LOG2_DEPTH:0]    count;
    logic                        almost_full;
    logic                        almost_empty;
    logic                        overflow;
    logic                        underflow;

    modport master (
        output w_hs, r_hs, w_data, err_clr,
        input  r_data, w_ptr, r_ptr, w_back_out, r_back_out,
               count, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  w_hs, r_hs, w_data, err_clr,
        output r_data, w_ptr, r_ptr, w_back_out, r_back_out,
               count, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/kim_fifo_mem_ptr.sv
// kim_fifo_mem_ptr
// Storage and pointer stage of the FIFO. Writes mem[w_ptr] on w_hs, presents
// mem[r_ptr] combinationally (fall-through), advances pointers with explicit
// wrap at DEPTH-1 and toggles the wrap ("back") bits, derives occupancy and
// almost flags, and keeps sticky overflow/underflow diagnostics.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (memory contents are kept)
//   fifo_if : slave side of kim_fifo_mem_ptr_if (strobes/data in, status out)
module kim_fifo_mem_ptr #(
    parameter int FIFO_DATA_LENGTH = 32,
    parameter int FIFO_DATA_DEPTH  = 4,
    parameter int FIFO_LOG2_DEPTH  = 2,
    parameter int AF_LEVEL         = 3,
    parameter int AE_LEVEL         = 1
) (
    input  logic               clk,
    input  logic               rst,
    kim_fifo_mem_ptr_if.slave  fifo_if
);
    localparam int CW = FIFO_LOG2_DEPTH + 1;

    typedef logic [FIFO_LOG2_DEPTH-1:0] ptr_t;

    localparam ptr_t LAST_IDX = ptr_t'(FIFO_DATA_DEPTH - 1);

    logic [FIFO_DATA_LENGTH-1:0] mem_q [FIFO_DATA_DEPTH];

    ptr_t       w_ptr_q, w_ptr_d;
    ptr_t       r_ptr_q, r_ptr_d;
    logic       w_back_q, w_back_d;
    logic       r_back_q, r_back_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;
    logic       full, empty;
    logic [CW-1:0] count_c;

    // Explicit compare against DEPTH-1 so non-power-of-two depths wrap correctly.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == LAST_IDX) return '0;
        return p + ptr_t'(1);
    endfunction

    assign full  = (w_ptr_q == r_ptr_q) && (w_back_q != r_back_q);
    assign empty = (w_ptr_q == r_ptr_q) && (w_back_q == r_back_q);

    // Unequal back bits mean the writer is one lap ahead of the reader.
    assign count_c = (w_back_q == r_back_q)
                   ? ({1'b0, w_ptr_q} - {1'b0, r_ptr_q})
                   : (CW'(FIFO_DATA_DEPTH) - {1'b0, r_ptr_q} + {1'b0, w_ptr_q});

    always_comb begin
        w_ptr_d  = w_ptr_q;
        w_back_d = w_back_q;
        r_ptr_d  = r_ptr_q;
        r_back_d = r_back_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (fifo_if.w_hs) begin
            w_ptr_d = ptr_inc(w_ptr_q);
            if (w_ptr_q == LAST_IDX) w_back_d = ~w_back_q;
        end
        if (fifo_if.r_hs) begin
            r_ptr_d = ptr_inc(r_ptr_q);
            if (r_ptr_q == LAST_IDX) r_back_d = ~r_back_q;
        end

        // Clear first so a same-cycle new error keeps the flag set.
        if (fifo_if.err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (fifo_if.w_hs && full && !fifo_if.r_hs)  ovf_d = 1'b1;
        if (fifo_if.r_hs && empty && !fifo_if.w_hs) udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            w_back_q <= 1'b0;
            r_back_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            w_ptr_q  <= w_ptr_d;
            r_ptr_q  <= r_ptr_d;
            w_back_q <= w_back_d;
            r_back_q <= r_back_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is intentionally not reset; stale words are unreachable after reset.
    always_ff @(posedge clk) begin
        if (fifo_if.w_hs && !rst) mem_q[w_ptr_q] <= fifo_if.w_data;
    end

    assign fifo_if.r_data       = mem_q[r_ptr_q];
    assign fifo_if.w_ptr        = w_ptr_q;
    assign fifo_if.r_ptr        = r_ptr_q;
    assign fifo_if.w_back_out   = w_back_q;
    assign fifo_if.r_back_out   = r_back_q;
    assign fifo_if.count        = count_c;
    assign fifo_if.almost_full  = int'(count_c) >= AF_LEVEL;
    assign fifo_if.almost_empty = int'(count_c) <= AE_LEVEL;
    assign fifo_if.overflow     = ovf_q;
    assign fifo_if.underflow    = udf_q;
endmodule

// File: tb/tb_kim_fifo_mem_ptr.sv
module tb_kim_fifo_mem_ptr;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int L  = 2;
    localparam int AF = 3;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic rst;

    kim_fifo_mem_ptr_if #(.FIFO_DATA_LENGTH(W), .FIFO_LOG2_DEPTH(L)) bus ();

    kim_fifo_mem_ptr #(
        .FIFO_DATA_LENGTH (W),
        .FIFO_DATA_DEPTH  (D),
        .FIFO_LOG2_DEPTH  (L),
        .AF_LEVEL         (AF),
        .AE_LEVEL         (AE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo_if (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: total strobes seen since reset, a queue of stored words,
    // and the sticky flags. Positions follow from plain division/modulo.
    int          wr_tot, rd_tot;
    logic [W-1:0] q[$];
    logic        q_ok;
    logic        ovf_m, udf_m;

    function automatic int occ();
        int c;
        c = (wr_tot - rd_tot) % (2 * D);
        if (c < 0) c += 2 * D;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int c;
        c = occ();
        chk({tag, ".w_ptr"},  64'(bus.w_ptr),      64'(wr_tot % D));
        chk({tag, ".w_back"}, 64'(bus.w_back_out), 64'((wr_tot / D) % 2));
        chk({tag, ".r_ptr"},  64'(bus.r_ptr),      64'(rd_tot % D));
        chk({tag, ".r_back"}, 64'(bus.r_back_out), 64'((rd_tot / D) % 2));
        chk({tag, ".count"},  64'(bus.count),      64'(c));
        chk({tag, ".af"},     64'(bus.almost_full),  64'(c >= AF));
        chk({tag, ".ae"},     64'(bus.almost_empty), 64'(c <= AE));
        chk({tag, ".ovf"},    64'(bus.overflow),   64'(ovf_m));
        chk({tag, ".udf"},    64'(bus.underflow),  64'(udf_m));
        if (q_ok && q.size() > 0) chk({tag, ".r_data"}, 64'(bus.r_data), 64'(q[0]));
    endtask

    // Called at posedge+1: drive strobes, look at the head before the edge,
    // then advance the model across the edge and compare everything.
    task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                        input logic clr, input string tag);
        int c;
        bus.w_hs = w; bus.r_hs = r; bus.w_data = d; bus.err_clr = clr;
        #1;
        if (q_ok && q.size() > 0 && r) chk({tag, ".head_pre"}, 64'(bus.r_data), 64'(q[0]));
        @(posedge clk);
        #1;
        c = occ();
        if (clr) begin ovf_m = 1'b0; udf_m = 1'b0; end
        if (w && !r && c == D) begin ovf_m = 1'b1; q_ok = 1'b0; end
        if (r && !w && c == 0) udf_m = 1'b1;
        if (w && r) begin
            if (q.size() > 0) begin
                void'(q.pop_front());
                q.push_back(d);
            end
        end else if (w) begin
            if (q.size() < D) q.push_back(d);
        end else if (r) begin
            if (q.size() > 0) void'(q.pop_front());
        end
        wr_tot += int'(w);
        rd_tot += int'(r);
        bus.w_hs = 1'b0; bus.r_hs = 1'b0; bus.err_clr = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input int n, input string tag);
        rst = 1'b1;
        bus.w_hs = 1'b0; bus.r_hs = 1'b0; bus.err_clr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_tot = 0; rd_tot = 0; q.delete(); q_ok = 1'b1;
        ovf_m = 1'b0; udf_m = 1'b0;
        check_state(tag);
    endtask

    initial begin
        logic w, r, clr;
        bus.w_hs = 1'b0; bus.r_hs = 1'b0; bus.w_data = '0; bus.err_clr = 1'b0;
        rst = 1'b1;
        #1;

        // Reset then idle
        do_reset(2, "reset");
        step(1'b0, 1'b0, '0, 1'b0, "idle");

        // Fill A0..A3
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(32'hA0 + i), 1'b0, "fill");
        chk("fill.head", 64'(bus.r_data), 64'h0A0);

        // Drain, head checked before each edge
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0, 1'b0, "drain");

        // Simultaneous strobes while empty (bypass)
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, W'($urandom), 1'b0, "bypass");

        // Simultaneous strobes while full
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'($urandom), 1'b0, "fill2");
        step(1'b1, 1'b1, W'(32'hB0), 1'b0, "full_wr");
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0, 1'b0, "drain2");

        // Errors: overflow, drain, underflow, clear
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'($urandom), 1'b0, "fill3");
        step(1'b1, 1'b0, W'(32'hEE), 1'b0, "overflow");
        for (int i = 0; i < D + 1; i++) step(1'b0, 1'b1, '0, 1'b0, "drain3");
        step(1'b0, 1'b1, '0, 1'b0, "underflow");
        step(1'b0, 1'b0, '0, 1'b1, "err_clr");
        do_reset(1, "reset2");
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'($urandom), 1'b0, "fill4");
        step(1'b1, 1'b0, W'(32'hEF), 1'b1, "clr_vs_ovf");

        // Reset mid-stream
        do_reset(1, "reset3");
        step(1'b1, 1'b0, W'(32'h11), 1'b0, "pre_rst");
        step(1'b1, 1'b0, W'(32'h22), 1'b0, "pre_rst");
        do_reset(1, "mid_rst");
        step(1'b1, 1'b0, W'(32'hC5), 1'b0, "post_rst_wr");
        chk("post_rst.head", 64'(bus.r_data), 64'h0C5);
        step(1'b0, 1'b1, '0, 1'b0, "post_rst_rd");

        // Random legal traffic
        for (int i = 0; i < 400; i++) begin
            w   = 1'($urandom);
            r   = 1'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            if (w && !r && occ() == D) w = 1'b0;
            if (r && !w && occ() == 0) r = 1'b0;
            step(w, r, W'($urandom), clr, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
